// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 7-segment scanner: double-buffered hex display with optional
// leading-zero blanking and per-slot dead time against ghosting.
module seven_segment_scanner #(
   parameter int clk_mhz          = 50,
   parameter int w_digit          = 8,
   parameter int cycles_per_digit = 50000,
   parameter int blank_cycles     = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4*w_digit-1:0]   number,
   input  logic [w_digit-1:0]     dots,
   input  logic                   blank_lz,
   input  logic                   load,
   output logic [7:0]             abcdefgh,
   output logic [w_digit-1:0]     digit,
   output logic                   frame_done
);

   localparam int TW = $clog2(cycles_per_digit);
   localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(cycles_per_digit - 1);
   localparam logic [IW-1:0] INDEX_LAST = IW'(w_digit - 1);

   if (clk_mhz < 1 || w_digit < 1 || cycles_per_digit < 2 ||
       blank_cycles < 0 || blank_cycles >= cycles_per_digit) begin : g_param_check
      $error("seven_segment_scanner: illegal parameter combination");
   end

   logic [TW-1:0]          tick_q,  tick_d;
   logic [IW-1:0]          index_q, index_d;
   logic [4*w_digit-1:0]   pend_num_q, act_num_q;
   logic [w_digit-1:0]     pend_dots_q, act_dots_q;
   logic                   pend_blz_q, act_blz_q;
   logic [7:0]             seg_q, seg_d;
   logic [w_digit-1:0]     digit_q, digit_d;
   logic                   frame_done_q;

   logic                   tick_wrap;
   logic                   frame_end;
   logic                   in_dead;
   logic [3:0]             cur_nib;
   logic                   cur_dot;
   logic                   cur_blank;
   logic                   zero_run;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1111110;
         4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;
         4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;
         4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;
         4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;
         4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   if (blank_cycles == 0) begin : g_no_dead
      assign in_dead = 1'b0;
   end else begin : g_dead
      assign in_dead = (tick_q < TW'(blank_cycles));
   end

   assign tick_wrap = (tick_q == TICK_LAST);
   assign frame_end = tick_wrap && (index_q == INDEX_LAST);

   always_comb begin
      tick_d  = tick_wrap ? '0 : tick_q + TW'(1);
      index_d = index_q;
      if (tick_wrap) begin
         index_d = (index_q == INDEX_LAST) ? '0 : index_q + IW'(1);
      end
   end

   // Walk from the top digit down: zero_run stays set while every nibble seen so far is zero.
   always_comb begin
      cur_nib   = 4'd0;
      cur_dot   = 1'b0;
      cur_blank = 1'b0;
      zero_run  = act_blz_q;
      digit_d   = '0;
      for (int i = w_digit - 1; i >= 0; i--) begin
         zero_run = zero_run && (act_num_q[4*i +: 4] == 4'd0);
         if (index_q == IW'(i)) begin
            cur_nib    = act_num_q[4*i +: 4];
            cur_dot    = act_dots_q[i];
            cur_blank  = zero_run && (i != 0);
            digit_d[i] = !in_dead;
         end
      end
      seg_d = {(cur_blank ? 7'd0 : hex_to_seg(cur_nib)), cur_dot};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q       <= '0;
         index_q      <= '0;
         pend_num_q   <= '0;
         pend_dots_q  <= '0;
         pend_blz_q   <= 1'b0;
         act_num_q    <= '0;
         act_dots_q   <= '0;
         act_blz_q    <= 1'b0;
         seg_q        <= '0;
         digit_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         tick_q  <= tick_d;
         index_q <= index_d;
         if (load) begin
            pend_num_q  <= number;
            pend_dots_q <= dots;
            pend_blz_q  <= blank_lz;
         end
         // A load coinciding with the frame boundary bypasses the pending buffer.
         if (frame_end) begin
            act_num_q  <= load ? number   : pend_num_q;
            act_dots_q <= load ? dots     : pend_dots_q;
            act_blz_q  <= load ? blank_lz : pend_blz_q;
         end
         seg_q        <= seg_d;
         digit_q      <= digit_d;
         frame_done_q <= frame_end;
      end
   end

   assign abcdefgh   = seg_q;
   assign digit      = digit_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: per-cycle reference model feeding an expected
// queue, plus directed per-slot segment expectations for each scenario.
module tb_seven_segment_scanner;

   localparam int W     = 4;
   localparam int CPD   = 4;
   localparam int BLANK = 1;
   localparam int FRAME = W * CPD;

   localparam logic [7:0] SEG_TAB [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   number = '0;
   logic [3:0]    dots = '0;
   logic          blank_lz = 1'b0;
   logic          load = 1'b0;
   logic [7:0]    abcdefgh;
   logic [3:0]    digit;
   logic          frame_done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [12:0] exp_q[$];

   int          m_cyc;
   logic [15:0] m_pend_num, m_act_num;
   logic [3:0]  m_pend_dots, m_act_dots;
   logic        m_pend_blz, m_act_blz;

   bit          dir_en = 1'b0;
   logic [7:0]  dir_seg [4];
   int          last_t, last_i;

   int          ld_at   [2] = '{-1, -1};
   logic [15:0] ld_num  [2];
   logic [3:0]  ld_dots [2];
   logic        ld_blz  [2];

   seven_segment_scanner #(
      .clk_mhz          (50),
      .w_digit          (W),
      .cycles_per_digit (CPD),
      .blank_cycles     (BLANK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .number     (number),
      .dots       (dots),
      .blank_lz   (blank_lz),
      .load       (load),
      .abcdefgh   (abcdefgh),
      .digit      (digit),
      .frame_done (frame_done)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // reference model
   function automatic logic [12:0] model_out();
      int t, i, hi;
      logic [7:0] seg;
      logic [3:0] dig;
      t   = m_cyc % CPD;
      i   = m_cyc / CPD;
      dig = (t < BLANK) ? 4'b0000 : 4'(1 << i);
      seg = SEG_TAB[m_act_num[i*4 +: 4]];
      hi  = -1;
      for (int k = 0; k < W; k++) if (m_act_num[k*4 +: 4] != 4'd0) hi = k;
      if (m_act_blz && i > 0 && i > hi) seg = 8'h00;
      seg[0] = m_act_dots[i];
      return {(m_cyc == FRAME - 1), dig, seg};
   endfunction

   task automatic model_update();
      if (load) begin
         m_pend_num  = number;
         m_pend_dots = dots;
         m_pend_blz  = blank_lz;
      end
      if (m_cyc == FRAME - 1) begin
         m_act_num  = m_pend_num;
         m_act_dots = m_pend_dots;
         m_act_blz  = m_pend_blz;
         m_cyc      = 0;
      end else begin
         m_cyc++;
      end
   endtask

   task automatic model_reset();
      m_cyc       = 0;
      m_pend_num  = '0;
      m_pend_dots = '0;
      m_pend_blz  = 1'b0;
      m_act_num   = '0;
      m_act_dots  = '0;
      m_act_blz   = 1'b0;
   endtask

   // driver tasks
   task automatic step();
      logic [12:0] e;
      last_t = m_cyc % CPD;
      last_i = m_cyc / CPD;
      exp_q.push_back(model_out());
      model_update();
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scan_queue_empty", 16'd1, 16'd0);
      end else begin
         e = exp_q.pop_front();
         check("scan", {3'b000, frame_done, digit, abcdefgh}, {3'b000, e});
      end
      if (dir_en && last_t == 1)
         check($sformatf("slot%0d", last_i), {8'h00, abcdefgh}, {8'h00, dir_seg[last_i]});
   endtask

   task automatic set_load(input int j, input int at, input logic [15:0] n,
                           input logic [3:0] d, input logic b);
      ld_at[j]   = at;
      ld_num[j]  = n;
      ld_dots[j] = d;
      ld_blz[j]  = b;
   endtask

   task automatic run_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         load     = 1'b0;
         number   = 16'($urandom_range(0, 65535));
         dots     = 4'($urandom_range(0, 15));
         blank_lz = 1'($urandom_range(0, 1));
         for (int j = 0; j < 2; j++) begin
            if (ld_at[j] == m_cyc) begin
               load     = 1'b1;
               number   = ld_num[j];
               dots     = ld_dots[j];
               blank_lz = ld_blz[j];
            end
         end
         step();
      end
      load     = 1'b0;
      ld_at[0] = -1;
      ld_at[1] = -1;
   endtask

   task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
      dir_seg[0] = e0;
      dir_seg[1] = e1;
      dir_seg[2] = e2;
      dir_seg[3] = e3;
      dir_en     = 1'b1;
      run_cycles(FRAME);
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b0;
      #1;
      check("rst_digit", {12'h000, digit}, 16'h0000);
      check("rst_seg", {8'h00, abcdefgh}, 16'h0000);
      check("rst_frame_done", {15'h0000, frame_done}, 16'h0000);
      model_reset();
      exp_q.delete();
      repeat (hold) begin
         @(posedge clk);
         #1;
         check("rst_hold", {3'b000, frame_done, digit, abcdefgh}, 16'h0000);
      end
      rst = 1'b1;
   endtask

   initial begin
      #2;
      do_reset(3);

      // power-up frames show zeros on every digit
      run_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);
      run_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);

      // load mid-frame: current frame unchanged, next frame shows it
      set_load(0, 5, 16'h1234, 4'b0000, 1'b0);
      run_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);
      run_frame(8'h66, 8'hF2, 8'hDA, 8'h60);

      // leading-zero blanking on, then off
      set_load(0, 2, 16'h0050, 4'b0100, 1'b1);
      run_frame(8'h66, 8'hF2, 8'hDA, 8'h60);
      run_frame(8'hFC, 8'hB6, 8'h01, 8'h00);
      set_load(0, 3, 16'h0050, 4'b0100, 1'b0);
      run_frame(8'hFC, 8'hB6, 8'h01, 8'h00);
      run_frame(8'hFC, 8'hB6, 8'hFD, 8'hFC);

      // load in the frame-boundary cycle overrides an earlier pending value
      set_load(0, 6, 16'h1111, 4'b0000, 1'b0);
      set_load(1, FRAME - 1, 16'hABCD, 4'b0000, 1'b0);
      run_frame(8'hFC, 8'hB6, 8'hFD, 8'hFC);
      run_frame(8'h7A, 8'h9C, 8'h3E, 8'hEE);
      run_frame(8'h7A, 8'h9C, 8'h3E, 8'hEE);

      // last load in a frame wins
      set_load(0, 4, 16'h5555, 4'b0000, 1'b0);
      set_load(1, 6, 16'h9999, 4'b0000, 1'b0);
      run_frame(8'h7A, 8'h9C, 8'h3E, 8'hEE);
      run_frame(8'hF6, 8'hF6, 8'hF6, 8'hF6);

      // reset in slot 2 discards the pending value
      set_load(0, 3, 16'h7777, 4'b0000, 1'b0);
      dir_seg[0] = 8'hF6;
      dir_seg[1] = 8'hF6;
      dir_seg[2] = 8'hF6;
      dir_seg[3] = 8'hF6;
      run_cycles(10);
      #2;
      do_reset(2);
      run_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);
      run_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed 7-segment display driver for the board `top` output side: takes a w_digit-nibble hex number plus per-digit dots from lab logic and scans it onto the shared `abcdefgh` segment bus and the `digit` select lines, one digit per slot. Double-buffered so a displayed frame never mixes two values; optional leading-zero blanking and anti-ghosting dead time.

## Interface
- `clk_mhz`, 50: board clock frequency; documentation only, not used in arithmetic.
- `w_digit`, 8: number of digits, ≥ 1.
- `cycles_per_digit`, 50000: clocks per digit slot, ≥ 2.
- `blank_cycles`, 2: dead-time clocks at the start of each slot with all `digit` lines low; 0 ≤ blank_cycles < cycles_per_digit.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `number`  in  4*w_digit  hex value; nibble i drives digit i, where nibble 0 is least significant.
- `dots`  in  w_digit  dot (`h` segment) request per digit.
- `blank_lz`  in  1  enable leading-zero blanking; sampled with `load`.
- `load`  in  1  one-cycle strobe that captures `number`, `dots` and `blank_lz` into the pending buffer.
- `abcdefgh`  out  8  segments, active-high; bit7 = a … bit1 = g, bit0 = h (dot).
- `digit`  out  w_digit  digit select, active-high, at most one bit set.
- `frame_done`  out  1  one-cycle pulse when a new frame starts.

## Operation
- State: `tick` counts 0..cycles_per_digit-1. `index` counts 0..w_digit-1 and advances when `tick` wraps; with w_digit = 1 it stays 0. Also held: a pending buffer and an active buffer.
- `load` = 1 writes the pending buffer. The next cycle's `load` overrides an earlier capture; the last one wins.
- Frame boundary is the cycle with `tick` = cycles_per_digit-1 and `index` = w_digit-1. On that edge `tick` and `index` go to 0 and the active buffer takes the pending buffer. If `load` is asserted in the same cycle, the active buffer takes the `load` inputs directly.
- Digit selection: `digit` = 0 while `tick` < blank_cycles, otherwise one-hot(`index`).
- Decoding of active nibble `index`:
  - 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0
  - 8 FE, 9 F6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E
  - bit0 = active dots[`index`].
- Leading-zero blanking, when the active `blank_lz` = 1: digit i > 0 is blank if nibbles w_digit-1..i are all zero. A blank digit drives segment bits 7..1 to 0 but still shows its dot. The digit line is still asserted. Digit 0 is never blanked.
- Reset (asynchronous, `rst` = 0) clears `tick`, `index`, both buffers, `abcdefgh`, `digit` and `frame_done` to 0 immediately. This also applies mid-frame.

## Timing
- Outputs are registered: `abcdefgh`, `digit` and `frame_done` at cycle t reflect `tick`, `index` and the active buffer at cycle t-1.
- `frame_done` is 1 in exactly the cycle after each frame-boundary edge.
- The first cycle after reset release is `tick` = 0, `index` = 0. That first frame shows all-zero data, i.e. digit 0 = FC and the other digits FC.
- Latency from `load` to display is up to one full frame (w_digit*cycles_per_digit clocks) plus 1.
- Each digit line is high for cycles_per_digit-blank_cycles consecutive clocks per frame, followed by ≥ blank_cycles clocks with all lines low.
- `number` and `dots` need only be valid in the `load` cycle.

## Test plan
Bench parameters: w_digit = 4, cycles_per_digit = 4, blank_cycles = 1.

- **Reset:** hold `rst` = 0 → all outputs 0.
  - Release → `digit` sequence per slot is 0000, 0001, 0001, 0001, then 0000, 0010, … (1-cycle output latency).
  - Segments FC on every digit.
  - `frame_done` pulses every 16 clocks.
- **Load mid-frame:** `load` with `number` = 0x1234, `dots` = 0 during slot 1 → the rest of that frame is unchanged (FC).
  - `frame_done` pulses.
  - Next frame: slot 0 = 66, slot 1 = F2, slot 2 = DA, slot 3 = 60.
- **Blanking:** `number` = 0x0050, `blank_lz` = 1, `dots` = 4'b0100 → slot 3 = 00, slot 2 = 01, slot 1 = B6, slot 0 = FC.
  - With `blank_lz` = 0: slot 3 = FC, slot 2 = FD.
- **Boundary load:** `load` 0xABCD exactly in the frame-boundary cycle, with 0x1111 loaded earlier in that frame → next frame shows 7A, 9C, 3E, EE; 0x1111 is never displayed.
- **Last-wins:** `load` 0x5555 then `load` 0x9999 two cycles later, same frame → next frame shows F6 on all digits.
- **Mid-frame reset:** assert `rst` = 0 in slot 2 → `digit`, `abcdefgh` and `frame_done` are 0 in the same cycle.
  - After release, the scan restarts at slot 0 with data 0 and the earlier pending value is lost.
